// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: the NOP encoding, control-transfer opcodes,
// the queue entry layout and a PC alignment helper.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One buffered fetch: the word and the PC it was read from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// Show-ahead FIFO of {pc, instr} entries between imem and decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, imem issue, response capture into the
// fetch queue, redirect flush and misaligned-redirect reporting.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          misalign_q, misalign_d;

  fetch_entry_t  q_head, q_push_data;
  logic          q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_count, occupancy;
  logic          issue;

  // Slots already promised to an in-flight read count as occupied, so the
  // queue can never be pushed while full.
  assign occupancy = q_count + CW'(inflight_q);
  assign issue     = !reset && !redirect_valid && (occupancy < CW'(QDEPTH));

  // A redirect this cycle kills the response arriving now; clearing the
  // in-flight flag at a redirect kills the one that would arrive next cycle.
  assign q_push      = inflight_q && !redirect_valid;
  assign q_push_data = '{pc: inflight_pc_q, instr: imem_rdata};
  assign q_pop       = id_valid && id_ready;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Next PC, in-flight tracking and misalign pulse.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_q    <= misalign_d;
      assert (!(q_push && q_full));
    end
  end

  // Interface outputs; an empty queue presents a NOP at RESET_PC.
  always_comb begin
    imem_req     = issue;
    imem_addr    = fetch_pc_q;
    id_valid     = !q_empty;
    id_instr     = q_empty ? NOP_INSTR : q_head.instr;
    id_pc        = q_empty ? RESET_PC  : q_head.pc;
    misalign_err = misalign_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hC000_0000 | {2'b00, a[31:2]};
  endfunction

  // Memory answers exactly one cycle after a request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memword(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Delivery scoreboard: program order, data integrity and hold-while-stalled.
  logic [31:0] exp_next = 32'h0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_rv = 1'b0, prev_reset = 1'b1;
  logic [31:0] prev_pc = '0, prev_instr = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_next = 32'h0;
    end else begin
      if (prev_valid && !prev_ready && !prev_rv && !prev_reset) begin
        chk("hold_valid", {31'b0, id_valid}, 32'd1);
        chk("hold_pc", id_pc, prev_pc);
        chk("hold_instr", id_instr, prev_instr);
      end
      if (redirect_valid) begin
        exp_next = {redirect_pc[31:2], 2'b00};
      end else if (id_valid && id_ready) begin
        chk("order_pc", id_pc, exp_next);
        chk("order_instr", id_instr, memword(id_pc));
        exp_next = id_pc + 32'd4;
      end
    end
    prev_valid = id_valid;
    prev_ready = id_ready;
    prev_rv    = redirect_valid;
    prev_reset = reset;
    prev_pc    = id_pc;
    prev_instr = id_instr;
  end

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t tbl [16];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = rdy;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, {31'b0, id_valid}, {31'b0, valid});
    if (valid) begin
      chk({tag, "_pc"}, id_pc, pc);
      chk({tag, "_instr"}, id_instr, memword(pc));
    end else begin
      chk({tag, "_nop"}, id_instr, NOP);
    end
  endtask

  initial begin
    int nreq;
    // rv  rpc        rdy req addr       valid pc        mis
    tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h000, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b1, 32'h004, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h008, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h014, 1'b1, 32'h00C, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h018, 1'b1, 32'h00C, 1'b0};
    tbl[7]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h01C, 1'b1, 32'h00C, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h000, 1'b0};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0};
    tbl[11] = '{1'b1, 32'h102, 1'b1, 1'b0, 32'h10C, 1'b1, 32'h104, 1'b0};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h000, 1'b0};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0};
    tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 1'b0};

    // Streaming, stall to 3 entries, aligned and misaligned redirects.
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      id_ready       = tbl[i].rdy;
      @(negedge clk);
      check_fetch($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc);
      chk($sformatf("vec%0d_mis", i), {31'b0, misalign_err}, {31'b0, tbl[i].mis});
      next_cycle();
    end

    // Back-to-back redirects: only the second target is fetched.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk); chk("b2b_r0_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    redirect_pc = 32'h80;
    @(negedge clk); check_fetch("b2b_r1", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); check_fetch("b2b_r2", 1'b1, 32'h80, 1'b0, 32'h0);
    next_cycle();
    @(negedge clk); check_fetch("b2b_r3", 1'b1, 32'h84, 1'b0, 32'h0);
    next_cycle();
    @(negedge clk); check_fetch("b2b_r4", 1'b1, 32'h88, 1'b1, 32'h80);
    next_cycle();
    repeat (3) next_cycle();

    // Decode stalled after reset: exactly QDEPTH requests, then drain in order.
    do_reset(1'b0);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) nreq++;
      if (c == 9) check_fetch("stall_c9", 1'b0, 32'h0, 1'b1, 32'h0);
      next_cycle();
    end
    chk("stall_nreq", nreq, 32'd4);
    id_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_valid", c), {31'b0, id_valid}, 32'd1);
      chk($sformatf("drain%0d_pc", c), id_pc, 32'(4 * c));
      next_cycle();
    end

    // Reset with a response in flight and the queue about to fill.
    do_reset(1'b0);
    repeat (4) next_cycle();
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("midrst_valid", {31'b0, id_valid}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    reset = 1'b0;
    id_ready = 1'b1;
    @(negedge clk); check_fetch("post_rst0", 1'b1, 32'h0, 1'b0, 32'h0);
    next_cycle();
    @(negedge clk); check_fetch("post_rst1", 1'b1, 32'h4, 1'b0, 32'h0);
    next_cycle();
    @(negedge clk); check_fetch("post_rst2", 1'b1, 32'h8, 1'b1, 32'h0);
    next_cycle();
    repeat (3) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
